// File: rtl/e_mdu_if.sv
// Handshake/bus bundle between the E-stage datapath and the multiply/divide unit.
//   master: drives start/op/req/A/B, observes busy/HI/LO/out
//   slave : the MDU itself
interface e_mdu_if;
  localparam int unsigned XLEN = 32;
  localparam int unsigned OPW  = 4;

  logic            start;
  logic [OPW-1:0]  op;
  logic            req;
  logic [XLEN-1:0] A;
  logic [XLEN-1:0] B;
  logic            busy;
  logic [XLEN-1:0] HI;
  logic [XLEN-1:0] LO;
  logic [XLEN-1:0] out;

  modport master (output start, op, req, A, B, input busy, HI, LO, out);
  modport slave  (input start, op, req, A, B, output busy, HI, LO, out);
endinterface

// File: rtl/e_mdu.sv
// E-stage multiply/divide unit with private HI/LO registers.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   bus        : e_mdu_if.slave
//                start/op/req/A/B in; busy, HI, LO registered out;
//                out is the combinational MFHI/MFLO read port.
// The result is computed at the accepting edge and held until the busy
// counter expires, so HI/LO only change at completion.
module e_mdu #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic    clk,
  input  logic    reset,
  e_mdu_if.slave  bus
);

  localparam int unsigned XLEN    = 32;
  localparam int unsigned MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W   = (MAX_CYC < 2) ? 1 : $clog2(MAX_CYC + 1);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MFHI  = 4'd7;
  localparam logic [3:0] OP_MFLO  = 4'd8;

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_RUN = 1'b1} state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              busy_q, busy_d;
  logic [XLEN-1:0]   hi_q, hi_d;
  logic [XLEN-1:0]   lo_q, lo_d;
  logic [XLEN-1:0]   res_hi_q, res_hi_d;
  logic [XLEN-1:0]   res_lo_q, res_lo_d;
  logic              res_upd_q, res_upd_d;

  logic              accept_c;
  logic              signed_op;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   a_mag, b_mag, b_safe, q_mag, r_mag, quo, rem;
  logic [XLEN-1:0]   out_c;

  assign accept_c = bus.start && !bus.req && !busy_q;

  // Arithmetic datapath: sign-magnitude division so quotient truncates toward
  // zero and remainder follows the dividend; 0x80000000/-1 wraps naturally.
  always_comb begin : arith
    signed_op = (bus.op == OP_MULT) || (bus.op == OP_DIV);
    prod   = {{XLEN{signed_op & bus.A[XLEN-1]}}, bus.A}
           * {{XLEN{signed_op & bus.B[XLEN-1]}}, bus.B};
    a_mag  = (signed_op && bus.A[XLEN-1]) ? (XLEN'(0) - bus.A) : bus.A;
    b_mag  = (signed_op && bus.B[XLEN-1]) ? (XLEN'(0) - bus.B) : bus.B;
    // Divisor 0 is discarded later; keep the divider free of X.
    b_safe = (b_mag == '0) ? XLEN'(1) : b_mag;
    q_mag  = a_mag / b_safe;
    r_mag  = a_mag % b_safe;
    quo    = (signed_op && (bus.A[XLEN-1] ^ bus.B[XLEN-1])) ? (XLEN'(0) - q_mag) : q_mag;
    rem    = (signed_op && bus.A[XLEN-1]) ? (XLEN'(0) - r_mag) : r_mag;
  end

  // Next-state logic for the IDLE/RUN controller and HI/LO.
  always_comb begin : next_state
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    res_hi_d  = res_hi_q;
    res_lo_d  = res_lo_q;
    res_upd_d = res_upd_q;

    unique case (state_q)
      S_IDLE: begin
        if (accept_c) begin
          unique case (bus.op)
            OP_MULT, OP_MULTU: begin
              res_hi_d  = prod[2*XLEN-1:XLEN];
              res_lo_d  = prod[XLEN-1:0];
              res_upd_d = 1'b1;
              cnt_d     = CNT_W'(MULT_CYCLES);
              state_d   = S_RUN;
            end
            OP_DIV, OP_DIVU: begin
              res_hi_d  = rem;
              res_lo_d  = quo;
              res_upd_d = (bus.B != '0);
              cnt_d     = CNT_W'(DIV_CYCLES);
              state_d   = S_RUN;
            end
            OP_MTHI: hi_d = bus.A;
            OP_MTLO: lo_d = bus.A;
            default: ;
          endcase
        end
      end
      S_RUN: begin
        // Completion on the 1->0 step; a zero count also ends the run.
        if (cnt_q <= CNT_W'(1)) begin
          cnt_d   = '0;
          state_d = S_IDLE;
          if (res_upd_q) begin
            hi_d = res_hi_q;
            lo_d = res_lo_q;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (cnt_d != '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      res_hi_q  <= '0;
      res_lo_q  <= '0;
      res_upd_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      res_hi_q  <= res_hi_d;
      res_lo_q  <= res_lo_d;
      res_upd_q <= res_upd_d;
    end
  end

  // MFHI/MFLO read port, driven straight from the current op.
  always_comb begin : read_port
    out_c = '0;
    if (bus.op == OP_MFHI) out_c = hi_q;
    else if (bus.op == OP_MFLO) out_c = lo_q;
  end

  assign bus.busy = busy_q;
  assign bus.HI   = hi_q;
  assign bus.LO   = lo_q;
  assign bus.out  = out_c;

endmodule

// File: tb/tb_e_mdu.sv
// Testbench for e_mdu: directed scenarios plus randomized ops against a
// behavioural HI/LO model using plain integer arithmetic.
module tb_e_mdu;

  localparam logic [3:0] NONE  = 4'd0;
  localparam logic [3:0] MULT  = 4'd1;
  localparam logic [3:0] MULTU = 4'd2;
  localparam logic [3:0] DIV   = 4'd3;
  localparam logic [3:0] DIVU  = 4'd4;
  localparam logic [3:0] MTHI  = 4'd5;
  localparam logic [3:0] MTLO  = 4'd6;
  localparam logic [3:0] MFHI  = 4'd7;
  localparam logic [3:0] MFLO  = 4'd8;

  logic clk;
  logic reset;
  int   total;
  int   bad;
  logic [31:0] hi_m;
  logic [31:0] lo_m;

  e_mdu_if bus ();

  e_mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: effect of an accepted op on HI/LO and its busy length.
  task automatic model_apply(input logic [3:0] op, input logic [31:0] a,
                             input logic [31:0] b, output int cyc);
    longint          ps;
    longint unsigned pu;
    longint          qs;
    longint          rs;
    logic [63:0]     v;
    cyc = 0;
    case (op)
      MULT: begin
        ps = longint'($signed(a)) * longint'($signed(b));
        v = 64'(ps); hi_m = v[63:32]; lo_m = v[31:0]; cyc = 5;
      end
      MULTU: begin
        pu = longint'({32'd0, a}) * longint'({32'd0, b});
        v = 64'(pu); hi_m = v[63:32]; lo_m = v[31:0]; cyc = 5;
      end
      DIV: begin
        if (b != 0) begin
          qs = longint'($signed(a)) / longint'($signed(b));
          rs = longint'($signed(a)) % longint'($signed(b));
          v = 64'(qs); lo_m = v[31:0];
          v = 64'(rs); hi_m = v[31:0];
        end
        cyc = 10;
      end
      DIVU: begin
        if (b != 0) begin
          lo_m = a / b;
          hi_m = a % b;
        end
        cyc = 10;
      end
      MTHI: hi_m = a;
      MTLO: lo_m = a;
      default: ;
    endcase
  endtask

  // Present an op for one accepting edge; called at a negedge.
  task automatic issue(input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic rq);
    bus.start = 1'b1; bus.op = op; bus.A = a; bus.B = b; bus.req = rq;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.op = NONE; bus.req = 1'b0;
  endtask

  // Count consecutive busy negedges, bounded so a stuck busy cannot hang.
  task automatic count_busy(inout int n);
    while (bus.busy === 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b want=0", bus.busy); end
    total++; if (bus.HI !== 32'h0) begin bad++; $display("FAIL reset_hi got=%h want=0", bus.HI); end
    total++; if (bus.LO !== 32'h0) begin bad++; $display("FAIL reset_lo got=%h want=0", bus.LO); end
    total++; if (bus.out !== 32'h0) begin bad++; $display("FAIL reset_out got=%h want=0", bus.out); end
    hi_m = '0; lo_m = '0;
  endtask

  task automatic test_mult;
    int n, cyc;
    issue(MULT, 32'hFFFFFFFE, 32'd3, 1'b0);
    @(negedge clk);
    total++; if (bus.HI !== hi_m || bus.LO !== lo_m) begin
      bad++; $display("FAIL mult_early_update got=%h_%h want=%h_%h", bus.HI, bus.LO, hi_m, lo_m);
    end
    n = 0; count_busy(n);
    model_apply(MULT, 32'hFFFFFFFE, 32'd3, cyc);
    total++; if (n != 5) begin bad++; $display("FAIL mult_busy got=%0d want=5", n); end
    total++; if (bus.HI !== 32'hFFFFFFFF) begin bad++; $display("FAIL mult_hi got=%h want=ffffffff", bus.HI); end
    total++; if (bus.LO !== 32'hFFFFFFFA) begin bad++; $display("FAIL mult_lo got=%h want=fffffffa", bus.LO); end
    bus.op = MFLO; #1;
    total++; if (bus.out !== 32'hFFFFFFFA) begin bad++; $display("FAIL mflo got=%h want=fffffffa", bus.out); end
    bus.op = MFHI; bus.start = 1'b1; bus.req = 1'b1; #1;
    total++; if (bus.out !== 32'hFFFFFFFF) begin bad++; $display("FAIL mfhi got=%h want=ffffffff", bus.out); end
    bus.start = 1'b0; bus.req = 1'b0;
    bus.op = 4'd13; #1;
    total++; if (bus.out !== 32'h0) begin bad++; $display("FAIL out_other_op got=%h want=0", bus.out); end
    bus.op = NONE;
    @(negedge clk);
  endtask

  task automatic test_multu;
    int n, cyc;
    issue(MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
    @(negedge clk); n = 0; count_busy(n);
    model_apply(MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, cyc);
    total++; if (n != 5) begin bad++; $display("FAIL multu_busy got=%0d want=5", n); end
    total++; if (bus.HI !== 32'hFFFFFFFE || bus.LO !== 32'h1) begin
      bad++; $display("FAIL multu_result got=%h_%h want=fffffffe_00000001", bus.HI, bus.LO);
    end
  endtask

  task automatic test_div;
    int n, cyc;
    issue(DIV, 32'hFFFFFFF9, 32'd2, 1'b0);
    @(negedge clk); n = 0; count_busy(n);
    model_apply(DIV, 32'hFFFFFFF9, 32'd2, cyc);
    total++; if (n != 10) begin bad++; $display("FAIL div_busy got=%0d want=10", n); end
    total++; if (bus.HI !== 32'hFFFFFFFF || bus.LO !== 32'hFFFFFFFD) begin
      bad++; $display("FAIL div_result got=%h_%h want=ffffffff_fffffffd", bus.HI, bus.LO);
    end
    issue(DIVU, 32'hFFFFFFF9, 32'd2, 1'b0);
    @(negedge clk); n = 0; count_busy(n);
    model_apply(DIVU, 32'hFFFFFFF9, 32'd2, cyc);
    total++; if (bus.HI !== 32'h1 || bus.LO !== 32'h7FFFFFFC) begin
      bad++; $display("FAIL divu_result got=%h_%h want=00000001_7ffffffc", bus.HI, bus.LO);
    end
    issue(DIV, 32'h80000000, 32'hFFFFFFFF, 1'b0);
    @(negedge clk); n = 0; count_busy(n);
    model_apply(DIV, 32'h80000000, 32'hFFFFFFFF, cyc);
    total++; if (bus.HI !== 32'h0 || bus.LO !== 32'h80000000) begin
      bad++; $display("FAIL div_overflow got=%h_%h want=00000000_80000000", bus.HI, bus.LO);
    end
  endtask

  task automatic test_div_zero;
    int n, cyc;
    logic [31:0] lo_before;
    lo_before = bus.LO;
    issue(MTHI, 32'h1234, 32'h0, 1'b0);
    @(negedge clk);
    model_apply(MTHI, 32'h1234, 32'h0, cyc);
    total++; if (bus.busy !== 1'b0 || bus.HI !== 32'h1234) begin
      bad++; $display("FAIL mthi got busy=%0b hi=%h want busy=0 hi=00001234", bus.busy, bus.HI);
    end
    issue(DIV, 32'h55, 32'h0, 1'b0);
    @(negedge clk); n = 0; count_busy(n);
    model_apply(DIV, 32'h55, 32'h0, cyc);
    total++; if (n != 10) begin bad++; $display("FAIL divzero_busy got=%0d want=10", n); end
    total++; if (bus.HI !== 32'h1234 || bus.LO !== lo_before) begin
      bad++; $display("FAIL divzero_keep got=%h_%h want=00001234_%h", bus.HI, bus.LO, lo_before);
    end
    issue(MTLO, 32'hCAFE0001, 32'h0, 1'b0);
    @(negedge clk);
    model_apply(MTLO, 32'hCAFE0001, 32'h0, cyc);
    total++; if (bus.LO !== 32'hCAFE0001 || bus.HI !== 32'h1234) begin
      bad++; $display("FAIL mtlo got=%h_%h want=00001234_cafe0001", bus.HI, bus.LO);
    end
  endtask

  task automatic test_req_cancel;
    int n;
    issue(MULT, 32'd7, 32'd9, 1'b1);
    @(negedge clk); n = 0; count_busy(n);
    repeat (6) @(negedge clk);
    total++; if (n != 0) begin bad++; $display("FAIL req_busy got=%0d want=0", n); end
    total++; if (bus.HI !== hi_m || bus.LO !== lo_m) begin
      bad++; $display("FAIL req_hilo got=%h_%h want=%h_%h", bus.HI, bus.LO, hi_m, lo_m);
    end
  endtask

  task automatic test_start_during_busy;
    int n, cyc;
    issue(MULT, 32'd1000, 32'hFFFFFFF0, 1'b0);
    @(negedge clk); n = 0;
    while (bus.busy === 1'b1 && n < 100) begin
      n++;
      if (n == 2) begin bus.start = 1'b1; bus.op = MTHI; bus.A = 32'hDEAD; end
      else if (n == 3) begin bus.start = 1'b1; bus.op = DIV; bus.A = 32'd5; bus.B = 32'd1; end
      else begin bus.start = 1'b0; bus.op = NONE; end
      @(negedge clk);
    end
    bus.start = 1'b0; bus.op = NONE;
    model_apply(MULT, 32'd1000, 32'hFFFFFFF0, cyc);
    total++; if (n != 5) begin bad++; $display("FAIL busy_ignore_len got=%0d want=5", n); end
    total++; if (bus.HI !== hi_m || bus.LO !== lo_m) begin
      bad++; $display("FAIL busy_ignore_result got=%h_%h want=%h_%h", bus.HI, bus.LO, hi_m, lo_m);
    end
  endtask

  task automatic test_back_to_back;
    int n, cyc;
    issue(MULTU, 32'h00010000, 32'h00030000, 1'b0);
    @(negedge clk); n = 0; count_busy(n);
    model_apply(MULTU, 32'h00010000, 32'h00030000, cyc);
    issue(DIVU, 32'd100, 32'd7, 1'b0);
    @(negedge clk);
    total++; if (bus.busy !== 1'b1 || bus.HI !== 32'h3 || bus.LO !== 32'h0) begin
      bad++; $display("FAIL b2b_first got busy=%0b %h_%h want busy=1 00000003_00000000", bus.busy, bus.HI, bus.LO);
    end
    n = 0; count_busy(n);
    model_apply(DIVU, 32'd100, 32'd7, cyc);
    total++; if (n != 10 || bus.HI !== 32'd2 || bus.LO !== 32'd14) begin
      bad++; $display("FAIL b2b_second got n=%0d %h_%h want n=10 00000002_0000000e", n, bus.HI, bus.LO);
    end
  endtask

  task automatic test_random;
    logic [3:0]  ops [6];
    logic [3:0]  op;
    logic [31:0] a, b;
    logic        rq;
    int          n, cyc;
    ops[0] = MULT; ops[1] = MULTU; ops[2] = DIV; ops[3] = DIVU; ops[4] = MTHI; ops[5] = MTLO;
    for (int i = 0; i < 40; i++) begin
      op = ops[$urandom_range(0, 5)];
      a  = $urandom;
      b  = ($urandom_range(0, 7) == 0) ? 32'h0 : 32'($urandom);
      if ($urandom_range(0, 9) == 0) begin a = 32'h80000000; b = 32'hFFFFFFFF; end
      rq = ($urandom_range(0, 5) == 0);
      issue(op, a, b, rq);
      @(negedge clk); n = 0; count_busy(n);
      cyc = 0;
      if (!rq) model_apply(op, a, b, cyc);
      total++; if (n != cyc || bus.HI !== hi_m || bus.LO !== lo_m) begin
        bad++;
        $display("FAIL rand[%0d] op=%0d a=%h b=%h req=%0b got n=%0d %h_%h want n=%0d %h_%h",
                 i, op, a, b, rq, n, bus.HI, bus.LO, cyc, hi_m, lo_m);
      end
    end
    bus.op = MFHI; #1;
    total++; if (bus.out !== hi_m) begin bad++; $display("FAIL rand_mfhi got=%h want=%h", bus.out, hi_m); end
    bus.op = NONE;
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    int n;
    issue(MULT, 32'h12345678, 32'h9ABCDEF1, 1'b0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    hi_m = '0; lo_m = '0;
    total++; if (bus.busy !== 1'b0 || bus.HI !== 32'h0 || bus.LO !== 32'h0) begin
      bad++; $display("FAIL rst_mid got busy=%0b %h_%h want busy=0 0_0", bus.busy, bus.HI, bus.LO);
    end
    @(negedge clk);
    reset = 1'b0;
    n = 0;
    repeat (8) begin
      @(negedge clk);
      if (bus.busy === 1'b1) n++;
    end
    total++; if (n != 0 || bus.HI !== 32'h0 || bus.LO !== 32'h0) begin
      bad++; $display("FAIL rst_mid_after got busy_cycles=%0d %h_%h want 0 0_0", n, bus.HI, bus.LO);
    end
  endtask

  initial begin
    total = 0; bad = 0;
    hi_m = '0; lo_m = '0;
    reset = 1'b1;
    bus.start = 1'b0; bus.op = NONE; bus.req = 1'b0; bus.A = '0; bus.B = '0;
    test_reset;
    test_mult;
    test_multu;
    test_div;
    test_div_zero;
    test_req_cancel;
    test_start_during_busy;
    test_back_to_back;
    test_random;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/e_mdu.md
# e_mdu

Multiply/divide unit for the E stage of the 5-stage MIPS pipeline. It consumes the two source operands read from the register file in D and forwarded into E. It executes `mult`, `multu`, `div`, `divu`, `mthi`, `mtlo`, `mfhi` and `mflo` against private HI/LO registers. It exports `busy` so the hazard unit can stall MDU instructions in D while an operation is in flight.

## Interface
Parameters:
- `MULT_CYCLES`, default 5: busy cycles for `mult`/`multu`.
- `DIV_CYCLES`, default 10: busy cycles for `div`/`divu`.

Ports:
- `clk`  in  1: clock. The block has one clock; all state updates on its rising edge.
- `reset`  in  1: reset, synchronous and active-high.
- `start`  in  1: qualifies `op` for state-changing ops in the current E instruction.
- `op`  in  4: operation code.
  - 0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 MFHI, 8 MFLO.
  - 9–15 behave as NONE.
- `req`  in  1: exception/interrupt cancel of the E instruction. When 1, suppresses `start`.
- `A`  in  32: operand rs (forwarded).
- `B`  in  32: operand rt (forwarded).
- `busy`  out  1: operation in flight.
- `HI`  out  32: HI register.
- `LO`  out  32: LO register.
- `out`  out  32: read result for MFHI/MFLO.

## Operation
- **Accepted op:** an op is accepted at a rising edge when `start`=1, `req`=0 and `busy`=0.
  - If `busy`=1, `start` is ignored. The hazard unit guarantees this never happens.
- **MULT/MULTU:**
  - `A` and `B` are captured at the accepting edge.
  - The 64-bit product (signed / unsigned) is computed into an internal result register.
  - A down-counter is loaded with `MULT_CYCLES`.
- **DIV/DIVU:**
  - Operands are captured the same way; the counter is loaded with `DIV_CYCLES`.
  - LO = quotient, truncated toward zero. HI = remainder, with the sign of the dividend.
  - `divu` is unsigned.
  - Signed 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
  - Divisor 0: HI and LO keep their previous values. `busy` is still asserted for `DIV_CYCLES`.
- **Completion:** at the edge where the counter steps 1→0, HI/LO are loaded from the internal result.
- **MTHI/MTLO:** HI←A (MTHI) or LO←A (MTLO) at the accepting edge. No busy cycles.
- **MFHI/MFLO:** combinational.
  - `out` = HI when `op`=MFHI, LO when `op`=MFLO, otherwise 0.
  - Independent of `start` and `req`.
- **State machine:**
  - IDLE (counter 0) → RUN on an accepted mult/div.
  - RUN decrements each cycle and returns to IDLE when the counter reaches 0.
  - `busy` = (counter != 0).
- **`req` during RUN:** does not abort the in-flight operation. The instruction that started it has already committed past E.

## Timing
- **Reset:** HI=0, LO=0, `busy`=0, counter=0, `out` per `op` (0 when `op`=NONE).
  - Reset mid-operation aborts it: no HI/LO update, `busy`=0 next cycle.
- **Latency:** mult accepted at the edge ending cycle T.
  - `busy`=1 in cycles T+1..T+5.
  - New HI/LO visible from cycle T+6.
  - Div is the same with 10 cycles: `busy` in T+1..T+10, HI/LO new at T+11.
- **MTHI/MTLO:** new value visible in the cycle after the accepting edge. `busy` stays 0.
- **Stall contract:** the hazard unit stalls any MDU op in D when `busy`=1 or when E holds an accepted mult/div (`start`=1).
- **Back-to-back:** a new op accepted in the cycle `busy` drops (T+6 for mult) is legal. HI/LO are already updated at that point.

## Test plan
- Reset, then `mult` A=0xFFFFFFFE, B=3:
  - `busy`=1 exactly 5 cycles.
  - Then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
  - `mflo` `out`=0xFFFFFFFA.
- `multu` A=0xFFFFFFFF, B=0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001 after 5 cycles.
- `div` A=-7 (0xFFFFFFF9), B=2 → after 10 cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - `divu` same operands → LO=0x7FFFFFFC, HI=1.
- `mthi` A=0x1234, then `div` B=0 → after 10 busy cycles HI=0x1234, LO unchanged.
- `start`=1 with `req`=1 for `mult`:
  - `busy` stays 0; HI/LO unchanged.
  - Separately, `start` pulsed during `busy` is ignored.
- `reset` asserted at busy cycle 3 of a `mult` → next cycle `busy`=0, HI=LO=0, no later update.
